// File: rtl/frame_pkg.sv
// Shared types and constants for the frame parser slice.
package frame_pkg;

    // Parser states, one per field of the frame plus the output drain.
    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } frame_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         LEN_W        = 4;

    // Fold one byte into the running XOR checksum.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file, one write port, one
// combinational read port. Contents need no reset: every entry read
// during a drain was written by the payload of the same frame.
module frame_buf
    import frame_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem_q [MAX_LEN];

    // Write the addressed entry; out-of-range addresses hit nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (wr_en && (wr_addr == LEN_W'(i))) begin
                mem_q[i] <= wr_data;
            end
        end
    end

    // Combinational read; out-of-range addresses return zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_addr == LEN_W'(i)) begin
                rd_data = mem_q[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: rtl/frame_parser.sv
// Byte-level frame parser: SYNC, LEN, payload, XOR checksum. Verified
// payloads are released on a ready/valid stream, bad frames are flagged.
// Optional frame statistics counters: define FRAME_PARSER_STATS_EN.
module frame_parser
    import frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         MAX_LEN   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       drop,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t     state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic             drop_q, drop_d;
    logic             wr_en_s;
    logic [LEN_W-1:0] rd_addr_s;
    logic [7:0]       rd_data_s;

    frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (idx_q),
        .wr_data (byte_in),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state, checksum, buffer control and output stream logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        drop_d      = drop_q;
        wr_en_s     = 1'b0;
        // Drain prefetches the entry after the one being presented.
        rd_addr_s   = idx_q + 4'd1;
        case (state_q)
            HUNT: begin
                if (byte_valid && (byte_in == SYNC_BYTE)) begin
                    state_d = LEN;
                end else begin
                    state_d = HUNT;
                end
            end
            LEN: begin
                if (byte_valid) begin
                    if ((byte_in == 8'h00) || (byte_in > MAX_LEN_B)) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end else begin
                        len_d   = byte_in[LEN_W-1:0];
                        chk_d   = byte_in;
                        idx_d   = 4'd0;
                        state_d = PAYLOAD;
                    end
                end else begin
                    state_d = LEN;
                end
            end
            PAYLOAD: begin
                // SYNC_BYTE is ordinary data here: no mid-frame resync.
                if (byte_valid) begin
                    wr_en_s = 1'b1;
                    chk_d   = chk_fold(chk_q, byte_in);
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == (len_q - 4'd1)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
            CHECK: begin
                rd_addr_s = 4'd0;
                if (byte_valid) begin
                    if (byte_in == chk_q) begin
                        // First byte is presented together with the ok pulse.
                        frame_ok_d  = 1'b1;
                        out_valid_d = 1'b1;
                        out_byte_d  = rd_data_s;
                        out_last_d  = (len_q == 4'd1);
                        idx_d       = 4'd0;
                        state_d     = DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            DRAIN: begin
                // Input bytes cannot be buffered while draining.
                if (byte_valid) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = HUNT;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        out_byte_d = rd_data_s;
                        out_last_d = ((idx_q + 4'd1) == (len_q - 4'd1));
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // Parser state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            len_q       <= 4'd0;
            idx_q       <= 4'd0;
            chk_q       <= 8'h00;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign drop      = drop_q;

`ifdef FRAME_PARSER_STATS_EN
    logic [7:0] ok_cnt_q, ok_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating frame counters, bumped alongside each result pulse.
    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (frame_ok_d && (ok_cnt_q != 8'hFF)) begin
            ok_cnt_d = ok_cnt_q + 8'd1;
        end else begin
            ok_cnt_d = ok_cnt_q;
        end
        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_cnt_q  <= 8'h00;
            err_cnt_q <= 8'h00;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign ok_cnt  = 8'h00;
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_frame_parser.sv
// Directed testbench for frame_parser: a cycle table plus hand sequences
// for backpressure, drop and reset mid-payload.
module tb_frame_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic       drop;
    logic [7:0] ok_cnt;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

`ifdef FRAME_PARSER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .drop       (drop),
        .ok_cnt     (ok_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       rdy;
        logic       ok;
        logic       err;
        logic       vld;
        logic [7:0] ob;
        logic       last;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic bv, input logic [7:0] b, input logic rdy,
                                input logic ok, input logic err, input logic vld,
                                input logic [7:0] ob, input logic last);
        vec_t v;
        v.bv = bv; v.b = b; v.rdy = rdy; v.ok = ok; v.err = err;
        v.vld = vld; v.ob = ob; v.last = last;
        return v;
    endfunction

    // Input byte with no visible output activity expected.
    function automatic vec_t quiet(input logic [7:0] b);
        return mk(1'b1, b, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        byte_valid = bv;
        byte_in    = b;
        out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic vld, input logic [7:0] ob, input logic last);
        chk({name, " valid"}, {31'd0, out_valid}, {31'd0, vld});
        if (vld) begin
            chk({name, " byte"}, {24'd0, out_byte}, {24'd0, ob});
            chk({name, " last"}, {31'd0, out_last}, {31'd0, last});
        end
    endtask

    initial begin
        // Good frame A5 03 11 22 33 03, preceded by idle and hunt garbage.
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        vecs.push_back(quiet(8'h00));
        vecs.push_back(quiet(8'hFF));
        vecs.push_back(quiet(8'h3C));
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(quiet(8'h03));
        vecs.push_back(quiet(8'h11));
        vecs.push_back(quiet(8'h22));
        vecs.push_back(quiet(8'h33));
        vecs.push_back(mk(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        // Bad checksum A5 02 01 02 FF (correct would be 01).
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(quiet(8'h02));
        vecs.push_back(quiet(8'h01));
        vecs.push_back(quiet(8'h02));
        vecs.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        // Bad lengths 0 and 9, then an immediate LEN=1 frame hunted as sync.
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(mk(1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(quiet(8'h01));
        vecs.push_back(quiet(8'h7E));
        vecs.push_back(mk(1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7E, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        // LEN=MAX_LEN frame 01..07 A5 (sync value as data), CHK = 08^A5 = AD.
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(quiet(8'h08));
        for (int i = 1; i <= 7; i++) begin
            vecs.push_back(quiet(8'(i)));
        end
        vecs.push_back(quiet(8'hA5));
        vecs.push_back(mk(1'b1, 8'hAD, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0));
        for (int i = 2; i <= 7; i++) begin
            vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'(i), 1'b0));
        end
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));

        // Reset state.
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", {out_byte, out_valid, out_last, frame_ok, frame_err, drop}, 32'd0);
        chk("reset cnts", {ok_cnt, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven portion.
        foreach (vecs[i]) begin
            step(vecs[i].bv, vecs[i].b, vecs[i].rdy);
            chk($sformatf("v%0d ok", i), {31'd0, frame_ok}, {31'd0, vecs[i].ok});
            chk($sformatf("v%0d err", i), {31'd0, frame_err}, {31'd0, vecs[i].err});
            chk_out($sformatf("v%0d", i), vecs[i].vld, vecs[i].ob, vecs[i].last);
        end
        chk("tbl ok_cnt", {24'd0, ok_cnt}, STATS ? 32'd3 : 32'd0);
        chk("tbl err_cnt", {24'd0, err_cnt}, STATS ? 32'd3 : 32'd0);
        chk("tbl drop", {31'd0, drop}, 32'd0);

        // Backpressure: hold 22 for three cycles with out_ready low.
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        chk("bp ok", {31'd0, frame_ok}, 32'd1);
        chk_out("bp b0", 1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_out("bp b1", 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk_out($sformatf("bp hold%0d", i), 1'b1, 8'h22, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        chk_out("bp b2", 1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk_out("bp end", 1'b0, 8'h00, 1'b0);

        // Drop: A5 02 5A C3 9B, bytes arrive during drain incl. final handshake.
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'h9B, 1'b1);
        chk("dr ok", {31'd0, frame_ok}, 32'd1);
        chk_out("dr b0", 1'b1, 8'h5A, 1'b0);
        chk("dr drop0", {31'd0, drop}, 32'd0);
        step(1'b1, 8'h77, 1'b1);
        chk("dr drop1", {31'd0, drop}, 32'd1);
        chk_out("dr b1", 1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'hA5, 1'b1);
        chk_out("dr end", 1'b0, 8'h00, 1'b0);
        // Had that A5 been parsed, 01 55 54 would form a good frame.
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h55, 1'b1);
        step(1'b1, 8'h54, 1'b1);
        chk("dr noparse ok", {31'd0, frame_ok}, 32'd0);
        chk_out("dr noparse", 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("dr sticky", {31'd0, drop}, 32'd1);
        chk("dr ok_cnt", {24'd0, ok_cnt}, STATS ? 32'd5 : 32'd0);
        chk("dr err_cnt", {24'd0, err_cnt}, STATS ? 32'd3 : 32'd0);

        // Reset mid-payload after A5 04 11.
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'h04, 1'b1);
        step(1'b1, 8'h11, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst outs", {out_valid, out_last, frame_ok, frame_err, drop}, 32'd0);
        chk("rst byte", {24'd0, out_byte}, 32'd0);
        chk("rst cnts", {ok_cnt, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h7E, 1'b1);
        step(1'b1, 8'h7F, 1'b1);
        chk("post ok", {31'd0, frame_ok}, 32'd1);
        chk("post err", {31'd0, frame_err}, 32'd0);
        chk_out("post b0", 1'b1, 8'h7E, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk_out("post end", 1'b0, 8'h00, 1'b0);
        chk("post ok_cnt", {24'd0, ok_cnt}, STATS ? 32'd1 : 32'd0);
        chk("post err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_parser.md
# frame_parser

Byte-level frame parser sitting directly downstream of the serial bit-to-byte deserializer. It consumes one byte per `byte_valid` strobe, hunts for a sync byte, reads a length field, buffers the payload and checks an XOR checksum. Only verified payloads are released on a ready/valid output stream; bad frames are dropped and flagged.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 8: maximum payload length in bytes (1..15).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `byte_in`  in  8  byte from the deserializer.
- `byte_valid`  in  1  one-cycle strobe, `byte_in` is valid this cycle.
- `out_byte`  out  8  released payload byte.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  downstream accepts `out_byte`.
- `out_last`  out  1  qualifies the final payload byte of a frame.
- `frame_ok`  out  1  one-cycle pulse, checksum matched.
- `frame_err`  out  1  one-cycle pulse, bad length or checksum.
- `drop`  out  1  sticky, input byte arrived while draining.
- `ok_cnt`, `err_cnt`  out  8 each  frame statistics (see Configuration).

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CHK. CHK = LEN XOR all payload bytes.
- States: HUNT, LEN, PAYLOAD, CHECK, DRAIN. All transitions occur only on an edge where `byte_valid`=1, except in DRAIN.
- HUNT: byte == `SYNC_BYTE` -> LEN; any other byte is discarded silently.
- LEN: LEN == 0 or LEN > `MAX_LEN` -> pulse `frame_err`, go to HUNT. Otherwise latch LEN, seed checksum with LEN, clear the write index, go to PAYLOAD.
- PAYLOAD: write the byte to the buffer at the index, XOR it into the checksum, increment the index. After the LEN-th byte -> CHECK. A byte equal to `SYNC_BYTE` is treated as data; there is no resync mid-frame.
- CHECK: byte == checksum -> pulse `frame_ok`, go to DRAIN. Otherwise pulse `frame_err`, go to HUNT.
- DRAIN: present the buffer from index 0. Advance on `out_valid && out_ready`. `out_last`=1 on index LEN-1. The last handshake returns to HUNT.
- Any `byte_valid` in DRAIN is discarded and sets `drop`=1. Only `rst` clears `drop`.
- Arithmetic: checksum is 8-bit XOR. Index and length are 4-bit.

## Timing
- Reset values: state HUNT; `out_byte`=0, `out_valid`=0, `out_last`=0, `frame_ok`=0, `frame_err`=0, `drop`=0, `ok_cnt`=0, `err_cnt`=0.
- `rst` asserted mid-frame aborts immediately. Buffer contents become don't-care and no pulse is generated.
- Checksum byte accepted at edge t -> `frame_ok`/`frame_err` high for the cycle after t.
- On a good frame, `out_valid` rises together with `frame_ok`.
- Drain throughput is one byte per cycle with `out_ready` held high. A LEN=3 frame drains in 3 cycles and the parser is back in HUNT on the following edge.
- Output stream rules:
  - `out_byte`, `out_valid` and `out_last` are held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
- A `byte_valid` on the same edge as the final drain handshake is dropped, sets `drop`, and is not parsed.

## Configuration
- `FRAME_PARSER_STATS_EN`
  - Defined: `ok_cnt`/`err_cnt` increment on each `frame_ok`/`frame_err` pulse and saturate at 8'hFF.
  - Undefined: both ports are tied to 0 and no counter logic is synthesized.

## Structure
- Package `frame_pkg` holds:
  - state enum `frame_state_t` (HUNT, LEN, PAYLOAD, CHECK, DRAIN);
  - `SYNC_DEFAULT`=8'hA5;
  - `LEN_W`=4.
- Sub-module `frame_buf`: `MAX_LEN`x8 register file with one write port and one combinational read port, indexed by `LEN_W`-bit addresses. The FSM, checksum, output handshake and stats live in `frame_parser`.

## Test plan
- Good frame: A5 03 11 22 33 03 -> `frame_ok` pulse; output 11, 22, 33 with `out_last` on 33; `err_cnt`=0, `ok_cnt`=1.
- Bad checksum: A5 02 01 02 FF -> `frame_err` pulse; `out_valid` never asserted; `err_cnt`=1.
- Bad length: A5 00, then A5 09 with `MAX_LEN`=8 -> two `frame_err` pulses; the next byte is hunted as sync.
- Backpressure: good frame with `out_ready` low for 3 cycles on byte 22 -> `out_byte`=22 held stable; the sequence completes intact.
- Drop: `byte_valid` asserted during DRAIN -> `drop`=1 and stays 1; the drained payload is unchanged.
- Reset mid-payload: `rst` after A5 04 11 -> all outputs 0; a subsequent good frame parses correctly.
